ili_pio_pulse: RTL and testbench

- Parametrised Avalon-MM output PIO. Successor to the 1-bit TFT control-line PIO (RS/CS/WR/RD/RST) used by the ILI9341 driver software.
- Drives WIDTH output bits. Adds atomic set/clear registers and a hardware-timed pulse engine, so software can strobe WR/RD for a programmed number of clocks without two register writes.
- Sits on the Nios II Avalon bus next to the TFT data PIO.

---
 rtl/ili_pio_pulse.sv | 148 ++++++++++++++
 tb/tb_ili_pio_pulse.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ili_pio_pulse.sv
// rtl/ili_pio_pulse.sv - Avalon-MM output PIO with atomic set/clear and a hardware-timed pulse engine
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset_n      synchronous active-low reset
//   address      word register select (0 DATA, 1 STATUS, 2 PULSE_LEN, 4 OUTSET, 5 OUTCLEAR, 6 PULSE)
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data, low WIDTH bits used unless the register says otherwise
//   readdata     combinational read data, zero wait states, unused bits 0
//   out_port     pin outputs: data_out with the pulse mask inverted on top while busy
//   pulse_active high while a pulse is in progress

module ili_pio_pulse #(
  parameter int unsigned WIDTH         = 8,
  parameter logic [31:0] RESET_VALUE   = 32'h0000_0001,
  parameter int unsigned PULSE_W       = 8,
  parameter int unsigned DEFAULT_PULSE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_active
);

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE     = 3'd6;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [PULSE_W-1:0] CNT_ONE     = PULSE_W'(1);
  localparam logic [PULSE_W-1:0] LEN_RESET   = PULSE_W'(DEFAULT_PULSE);
  localparam logic [WIDTH-1:0]   DATA_RESET  = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0]   data_out_q,  data_out_d;
  logic [PULSE_W-1:0] pulse_len_q, pulse_len_d;
  logic [WIDTH-1:0]   mask_q,      mask_d;
  logic [PULSE_W-1:0] count_q,     count_d;
  logic [0:0]         state_q,     state_d;
  logic               overrun_q,   overrun_d;

  logic               wr;
  logic [WIDTH-1:0]   wd_w;
  logic               busy;
  logic [PULSE_W-1:0] start_count;
  logic               unused_wd;

  assign wr   = chipselect & ~write_n;
  assign wd_w = writedata[WIDTH-1:0];
  assign busy = (state_q == ST_ACTIVE);

  // Upper writedata bits only matter for some registers; fold them so the
  // whole bus is consumed regardless of WIDTH.
  assign unused_wd = ^writedata;

  // A programmed length of 0 behaves like 1; the counter holds cycles left
  // after the current one, so it starts at length-1.
  assign start_count = (pulse_len_q == '0) ? '0 : (pulse_len_q - CNT_ONE);

  always_comb begin
    data_out_d  = data_out_q;
    pulse_len_d = pulse_len_q;
    mask_d      = mask_q;
    count_d     = count_q;
    state_d     = state_q;
    overrun_d   = overrun_q;

    if (wr) begin
      case (address)
        ADDR_DATA:      data_out_d  = wd_w;
        ADDR_PULSE_LEN: pulse_len_d = writedata[PULSE_W-1:0];
        ADDR_OUTSET:    data_out_d  = data_out_q | wd_w;
        ADDR_OUTCLEAR:  data_out_d  = data_out_q & ~wd_w;
        ADDR_STATUS: begin
          if (writedata[1]) begin
            overrun_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (wr && (address == ADDR_PULSE) && (wd_w != '0)) begin
          mask_d  = wd_w;
          count_d = start_count;
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        if (count_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          count_d = count_q - CNT_ONE;
        end
        // Any pulse request while active, including on the final cycle,
        // is dropped and flagged; the set is evaluated last so it wins.
        if (wr && (address == ADDR_PULSE)) begin
          overrun_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out_q  <= DATA_RESET;
      pulse_len_q <= LEN_RESET;
      mask_q      <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      overrun_q   <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      pulse_len_q <= pulse_len_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      state_q     <= state_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata[WIDTH-1:0]   = data_out_q;
      ADDR_STATUS:    readdata[1:0]         = {overrun_q, busy};
      ADDR_PULSE_LEN: readdata[PULSE_W-1:0] = pulse_len_q;
      ADDR_PULSE:     readdata[WIDTH-1:0]   = mask_q;
      default:        readdata              = '0;
    endcase
  end

  assign out_port     = data_out_q ^ (busy ? mask_q : '0);
  assign pulse_active = busy;

endmodule

// File: tb/tb_ili_pio_pulse.sv
// tb/tb_ili_pio_pulse.sv - randomized self-checking bench for ili_pio_pulse against a cycle-count model

module tb_ili_pio_pulse;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        pulse_active;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a pulse is "rem cycles of inversion still to show".
  logic [7:0] m_data, m_len, m_mask;
  logic       m_ovr;
  int         rem;
  logic       obs_pa;

  always #5 clk = ~clk;

  ili_pio_pulse #(
    .WIDTH(8), .RESET_VALUE(32'h01), .PULSE_W(8), .DEFAULT_PULSE(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .pulse_active(pulse_active)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'd0, m_data};
      3'd1:    return {30'd0, m_ovr, (rem > 0)};
      3'd2:    return {24'd0, m_len};
      3'd6:    return {24'd0, m_mask};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [7:0] model_out();
    return m_data ^ ((rem > 0) ? m_mask : 8'h00);
  endfunction

  task automatic model_reset();
    m_data = 8'h01; m_len = 8'd1; m_mask = 8'h00; m_ovr = 1'b0; rem = 0;
  endtask

  task automatic model_edge(input logic rst_n_v, input logic we,
                            input logic [2:0] a, input logic [31:0] wd);
    logic was_busy;
    if (!rst_n_v) begin
      model_reset();
      return;
    end
    was_busy = (rem > 0);
    if (was_busy) rem--;
    if (we) begin
      case (a)
        3'd0: m_data = wd[7:0];
        3'd1: if (wd[1]) m_ovr = 1'b0;
        3'd2: m_len = wd[7:0];
        3'd4: m_data = m_data | wd[7:0];
        3'd5: m_data = m_data & ~wd[7:0];
        3'd6: begin
          if (was_busy) m_ovr = 1'b1;
          else if (wd[7:0] != 8'h00) begin
            m_mask = wd[7:0];
            rem = (m_len == 8'd0) ? 1 : int'(m_len);
          end
        end
        default: ;
      endcase
    end
  endtask

  // One bus cycle: drive, check the state left by the previous edge, clock, advance model.
  task automatic step(input logic rst_n_v, input logic we,
                      input logic [2:0] a, input logic [31:0] wd);
    @(negedge clk);
    reset_n = rst_n_v; chipselect = we; write_n = ~we; address = a; writedata = wd;
    #1;
    obs_pa = pulse_active;
    chk("out_port", {24'd0, out_port}, {24'd0, model_out()});
    chk("pulse_active", {31'd0, pulse_active}, {31'd0, (rem > 0)});
    chk($sformatf("readdata[%0d]", a), readdata, model_read(a));
    @(posedge clk);
    model_edge(rst_n_v, we, a, wd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    step(1'b1, 1'b1, a, wd);
  endtask

  task automatic idle(input logic [2:0] a);
    step(1'b1, 1'b0, a, $urandom);
  endtask

  task automatic measure_pulse(input string tag, input int exp_w);
    int w = 0;
    for (int i = 0; i < 40; i++) begin
      idle(3'd1);
      if (obs_pa) w++;
    end
    chk(tag, w, exp_w);
  endtask

  initial begin
    // Raw reset for two edges, then the model takes over.
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk); #1;
    chk("rst_out", {24'd0, out_port}, 32'h01);
    chk("rst_pa", {31'd0, pulse_active}, 32'd0);
    step(1'b1, 1'b0, 3'd1, 32'd0);
    step(1'b1, 1'b0, 3'd2, 32'd0);

    // Set / clear
    wr(3'd0, 32'hFFFF_FFA5);
    wr(3'd4, 32'h0000_000A);
    wr(3'd5, 32'h0000_0081);
    idle(3'd0);
    chk("setclr_out", {24'd0, out_port}, 32'h2E);

    // Pulse timing, length 3 then length 0
    wr(3'd2, 32'd3);
    wr(3'd0, 32'h01);
    wr(3'd6, 32'h04);
    measure_pulse("pulse_w3", 3);
    wr(3'd2, 32'd0);
    wr(3'd6, 32'h04);
    measure_pulse("pulse_w0", 1);
    wr(3'd6, 32'h00);
    idle(3'd1);
    chk("zero_mask_noop", {31'd0, pulse_active}, 32'd0);

    // Overrun
    wr(3'd2, 32'd10);
    wr(3'd6, 32'h02);
    idle(3'd1); idle(3'd1); idle(3'd1);
    wr(3'd6, 32'h08);
    for (int i = 0; i < 12; i++) idle(3'd1);
    chk("ovr_after", readdata, 32'h2);
    wr(3'd1, 32'h2);
    idle(3'd1);
    chk("ovr_cleared", readdata, 32'h0);

    // Data change mid-pulse
    wr(3'd2, 32'd5);
    wr(3'd0, 32'h00);
    wr(3'd6, 32'h01);
    idle(3'd0);
    wr(3'd0, 32'h03);
    for (int i = 0; i < 6; i++) idle(3'd0);
    chk("mid_data_end", {24'd0, out_port}, 32'h03);

    // Reset mid-pulse, then a normal pulse
    wr(3'd2, 32'd20);
    wr(3'd6, 32'hFF);
    repeat (4) idle(3'd1);
    step(1'b0, 1'b0, 3'd1, 32'd0);
    idle(3'd1);
    chk("rst_mid_out", {24'd0, out_port}, 32'h01);
    wr(3'd2, 32'd2);
    wr(3'd6, 32'h10);
    measure_pulse("pulse_after_rst", 2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      logic [2:0] a = 3'($urandom_range(0, 7));
      logic [31:0] wd = $urandom;
      if (a == 3'd2) wd = {wd[31:8], 8'($urandom_range(0, 7))};
      if (r < 1)       step(1'b0, 1'($urandom_range(0, 1)), a, wd);
      else if (r < 45) wr(a, wd);
      else             idle(a);
    end
    idle(3'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
